// File: rtl/lane_pack_pkg.sv
// Shared definitions for the lane packer and its wide-FIFO read-side unpacker.
// The packet layout is lane k at [k*WIDTH +: WIDTH] with the lane-valid mask
// occupying the top lanes-count bits.
package lane_pack_pkg;

    // Packer control states: collecting lanes, or holding a packet for write-out.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } lane_state_t;

    // Total packet width: all data lanes plus one mask bit per lane.
    function automatic int pk_width(input int width, input int m_lanes);
        return m_lanes * width + m_lanes;
    endfunction

    // Bit position of mask bit 0 inside the packet word.
    function automatic int mask_lsb(input int width, input int m_lanes);
        return m_lanes * width;
    endfunction

    // Bit position of lane k's data inside the packet word.
    function automatic int lane_lsb(input int width, input int k);
        return k * width;
    endfunction

endpackage

// File: rtl/lane_packer.sv
// Serial-to-wide packer: gathers WIDTH-bit words into an M_LANES-lane packet
// with a contiguous lane-valid mask and writes it to a wide FIFO. Partial
// packets leave on an explicit flush or after FLUSH_TO idle cycles.
//
// Handshakes: an input word transfers on any cycle where i_in_valid and
// o_in_ready are both high. A packet transfers on any cycle where o_pk_en is
// high; o_pk_en is only raised while i_pk_full is low, and o_pk_data is held
// stable for as long as the packet waits on a full FIFO.
module lane_packer
    import lane_pack_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int M_LANES  = 2,
    parameter int FLUSH_TO = 16
) (
    input  logic                                      i_clk,
    input  logic                                      i_rstn,
    input  logic                                      i_in_valid,
    output logic                                      o_in_ready,
    input  logic [WIDTH-1:0]                          i_in_data,
    input  logic                                      i_flush,
    output logic                                      o_pk_en,
    input  logic                                      i_pk_full,
    output logic [pk_width(WIDTH, M_LANES)-1:0]       o_pk_data,
    output logic [$clog2(M_LANES+1)-1:0]              o_lane_cnt
);

    localparam int MP = mask_lsb(WIDTH, M_LANES);
    localparam int CW = $clog2(M_LANES + 1);
    // Timer must hold FLUSH_TO itself; keep one bit when auto-emit is disabled.
    localparam int TW = (FLUSH_TO > 0) ? $clog2(FLUSH_TO + 1) : 1;

    lane_state_t              state_q, state_d;
    logic [M_LANES*WIDTH-1:0] data_q, data_d;
    logic [M_LANES-1:0]       mask_q, mask_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TW-1:0]            idle_q, idle_d;
    logic                     accept;
    logic                     last_lane;
    logic                     flush_go;
    logic                     timeout;

    // Next-state, lane writes, idle timer and handshake outputs.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        o_in_ready = (state_q == ST_FILL);
        o_pk_en    = 1'b0;
        accept     = 1'b0;
        last_lane  = 1'b0;
        flush_go   = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            ST_FILL: begin
                accept = i_in_valid;
                if (accept) begin
                    // Lanes fill strictly upward so the mask stays contiguous.
                    for (int k = 0; k < M_LANES; k++) begin
                        if (cnt_q == CW'(k)) begin
                            data_d[lane_lsb(WIDTH, k) +: WIDTH] = i_in_data;
                            mask_d[k] = 1'b1;
                        end
                    end
                    cnt_d     = cnt_q + CW'(1);
                    idle_d    = '0;
                    last_lane = (cnt_q == CW'(M_LANES - 1));
                end else if ((FLUSH_TO != 0) && (|mask_q)) begin
                    idle_d  = idle_q + TW'(1);
                    timeout = (idle_q == TW'(FLUSH_TO - 1));
                end
                // Flush looks at the post-accept mask so a coinciding word rides along.
                flush_go = i_flush && (|mask_d);
                if (last_lane || flush_go || timeout) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                o_pk_en = ~i_pk_full;
                if (o_pk_en) begin
                    data_d  = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
                    idle_d  = '0;
                    state_d = ST_FILL;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State, packet and timer registers; reset discards any partial packet.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_FILL;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

    // The packet word is the registered lanes plus mask, driven continuously.
    assign o_pk_data[MP +: M_LANES] = mask_q;
    assign o_pk_data[MP-1:0]        = data_q;
    assign o_lane_cnt               = cnt_q;

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer at WIDTH=8, M_LANES=2, FLUSH_TO=16.
module tb_lane_packer;

    logic        i_clk;
    logic        i_rstn;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_in_data;
    logic        i_flush;
    logic        o_pk_en;
    logic        i_pk_full;
    logic [17:0] o_pk_data;
    logic [1:0]  o_lane_cnt;

    int n_checks;
    int n_errors;

    lane_packer #(
        .WIDTH   (8),
        .M_LANES (2),
        .FLUSH_TO(16)
    ) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready),
        .i_in_data (i_in_data),
        .i_flush   (i_flush),
        .o_pk_en   (o_pk_en),
        .i_pk_full (i_pk_full),
        .o_pk_data (o_pk_data),
        .o_lane_cnt(o_lane_cnt)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; land 1 time unit past the edge, away from it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_in_valid = 1'b0;
        i_in_data  = 8'h00;
        i_flush    = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        i_in_valid = 1'b1;
        i_in_data  = d;
        tick();
        idle_inputs();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_en"},   {31'd0, o_pk_en},   32'd0);
        check({tag, "_rdy"},  {31'd0, o_in_ready}, 32'd1);
        check({tag, "_cnt"},  {30'd0, o_lane_cnt}, 32'd0);
        check({tag, "_data"}, {14'd0, o_pk_data},  32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        i_rstn    = 1'b0;
        i_pk_full = 1'b0;
        idle_inputs();

        // Reset values while held in reset
        #12;
        check_cleared("rst");
        i_rstn = 1'b1;

        // Two back-to-back words form a full packet, emitted one cycle later
        check("a_rdy0", {31'd0, o_in_ready}, 32'd1);
        i_in_valid = 1'b1;
        i_in_data  = 8'hA1;
        tick();
        check("a_en_mid", {31'd0, o_pk_en}, 32'd0);
        check("a_cnt1", {30'd0, o_lane_cnt}, 32'd1);
        i_in_data = 8'hA2;
        tick();
        idle_inputs();
        check("a_en", {31'd0, o_pk_en}, 32'd1);
        check("a_data", {14'd0, o_pk_data}, 32'h3A2A1);
        check("a_rdy_emit", {31'd0, o_in_ready}, 32'd0);
        check("a_cnt2", {30'd0, o_lane_cnt}, 32'd2);
        tick();
        check_cleared("a_after");

        // Partial packet released by flush on the following cycle
        push(8'h55);
        i_flush = 1'b1;
        check("f_en_pre", {31'd0, o_pk_en}, 32'd0);
        tick();
        idle_inputs();
        check("f_en", {31'd0, o_pk_en}, 32'd1);
        check("f_data", {14'd0, o_pk_data}, 32'h10055);
        tick();
        check_cleared("f_after");

        // Flush coinciding with an accept carries the new word
        i_in_valid = 1'b1;
        i_in_data  = 8'hD1;
        i_flush    = 1'b1;
        tick();
        idle_inputs();
        check("fa_en", {31'd0, o_pk_en}, 32'd1);
        check("fa_data", {14'd0, o_pk_data}, 32'h100D1);
        tick();

        // Idle timeout: nothing at 15 idle cycles, emit after the 16th
        push(8'h33);
        for (int i = 0; i < 15; i++) tick();
        check("t_en15", {31'd0, o_pk_en}, 32'd0);
        check("t_rdy15", {31'd0, o_in_ready}, 32'd1);
        tick();
        check("t_en16", {31'd0, o_pk_en}, 32'd1);
        check("t_data", {14'd0, o_pk_data}, 32'h10033);
        tick();
        check_cleared("t_after");

        // Backpressure: packet held stable and input blocked while full
        i_pk_full = 1'b1;
        push(8'hB1);
        push(8'hB2);
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'hCC;
            #1;
            check("bp_en", {31'd0, o_pk_en}, 32'd0);
            check("bp_rdy", {31'd0, o_in_ready}, 32'd0);
            check("bp_data", {14'd0, o_pk_data}, 32'h3B2B1);
            tick();
        end
        idle_inputs();
        i_pk_full = 1'b0;
        #1;
        check("bp_en_fall", {31'd0, o_pk_en}, 32'd1);
        check("bp_data_fall", {14'd0, o_pk_data}, 32'h3B2B1);
        tick();
        check_cleared("bp_after");

        // Reset after one accept discards it; a later flush emits nothing
        push(8'h77);
        check("r_cnt_pre", {30'd0, o_lane_cnt}, 32'd1);
        i_rstn = 1'b0;
        #1;
        check_cleared("r_in");
        tick();
        i_rstn  = 1'b1;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check_cleared("r_flush");
        tick();
        check("r_flush_en2", {31'd0, o_pk_en}, 32'd0);

        // Reset while a packet waits in EMIT
        i_pk_full = 1'b1;
        push(8'hE1);
        push(8'hE2);
        check("re_rdy_pre", {31'd0, o_in_ready}, 32'd0);
        i_rstn = 1'b0;
        #1;
        check_cleared("re_in");
        tick();
        i_rstn    = 1'b1;
        i_pk_full = 1'b0;
        tick();
        check_cleared("re_after");

        // Flush on empty mask is ignored
        i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("e_en", {31'd0, o_pk_en}, 32'd0);
            check("e_rdy", {31'd0, o_in_ready}, 32'd1);
        end
        idle_inputs();

        // Continuous stream: two words then a one-cycle emit gap
        i_in_valid = 1'b1;
        i_in_data  = 8'h11;
        tick();
        i_in_data = 8'h22;
        tick();
        i_in_data = 8'h33;
        check("s_rdy_gap", {31'd0, o_in_ready}, 32'd0);
        check("s_data", {14'd0, o_pk_data}, 32'h32211);
        tick();
        check("s_cnt_next", {30'd0, o_lane_cnt}, 32'd0);
        tick();
        idle_inputs();
        check("s_cnt_after", {30'd0, o_lane_cnt}, 32'd1);
        check("s_data2", {14'd0, o_pk_data}, 32'h10033);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
